multicycle_ctrl: RTL and testbench
==================================

MULTICYCLE_CTRL -- requirements
Module: multicycle_ctrl

Interface
REQ-001 The block SHALL have no parameters.
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 rst_n  input  1  reset, asynchronous, active-low.
REQ-004 op  input  7  opcode field of the instruction register.
REQ-005 Zero  input  1  ALU zero flag, valid in the BEQ state.
REQ-006 MemReady  input  1  memory handshake; current access completes in a cycle where it is 1.
REQ-007 PCWrite  output  1  PC register load enable.
REQ-008 PCSrc  output  1  PC source: 0 = result bus, 1 = ALUOut (branch/jump target).
REQ-009 AdrSrc  output  1  memory address: 0 = PC, 1 = ALUOut.
REQ-010 IRWrite  output  1  instruction register load enable.
REQ-011 MemWrite  output  1  memory write strobe.
REQ-012 RegWrite  output  1  register-file write enable.
REQ-013 ResultSrc  output  2  result mux select: 00 ALU_result, 01 ReadData, 10 PC_plus4, 11 ImmExt.
REQ-014 ALUSrcA  output  2  00 PC, 01 OldPC, 10 rs1.
REQ-015 ALUSrcB  output  2  00 rs2, 01 ImmExt, 10 constant 4.
REQ-016 ALUOp  output  2  00 add, 01 subtract/compare, 10 decode by funct.

Function
REQ-017 The block SHALL be a Moore FSM with states FETCH, DECODE, MEMADR, MEMREAD, MEMWB, MEMWRITE, EXECUTER, EXECUTEI, ALUWB, JAL, BEQ, LUI; outputs not listed for a state SHALL be 0.
REQ-018 FETCH: AdrSrc=0, ALUSrcA=00, ALUSrcB=10, ALUOp=00, ResultSrc=10; IRWrite=PCWrite=MemReady; go to DECODE when MemReady=1, otherwise hold.
REQ-019 DECODE: ALUSrcA=01, ALUSrcB=01, ALUOp=00 (target to ALUOut); next state by op: 0000011/0100011->MEMADR, 0110011->EXECUTER, 0010011->EXECUTEI, 1101111->JAL, 1100011->BEQ, 0110111->LUI, any other->FETCH (NOP).
REQ-020 MEMADR: ALUSrcA=10, ALUSrcB=01, ALUOp=00; op=0000011->MEMREAD, else MEMWRITE.
REQ-021 MEMREAD: AdrSrc=1; hold until MemReady=1, then MEMWB.
REQ-022 MEMWB: ResultSrc=01, RegWrite=1; ->FETCH.
REQ-023 MEMWRITE: AdrSrc=1, MemWrite=1 held continuously until the MemReady=1 cycle; ->FETCH on that cycle.
REQ-024 EXECUTER: ALUSrcA=10, ALUSrcB=00, ALUOp=10; EXECUTEI: ALUSrcA=10, ALUSrcB=01, ALUOp=10; both ->ALUWB.
REQ-025 ALUWB: ResultSrc=00, RegWrite=1; ->FETCH.
REQ-026 JAL: ResultSrc=10, RegWrite=1, PCSrc=1, PCWrite=1; ->FETCH.
REQ-027 BEQ: ALUSrcA=10, ALUSrcB=00, ALUOp=01, PCSrc=1, PCWrite=Zero; ->FETCH.
REQ-028 LUI: ResultSrc=11, RegWrite=1; ->FETCH.
REQ-029 With MemReady tied 1, latencies in cycles SHALL be: lw 5, sw 4, R/I-type 4, jal 3, beq 3, lui 3, unknown opcode 2.
REQ-030 MemReady SHALL be ignored in every state other than FETCH, MEMREAD and MEMWRITE.
REQ-031 op SHALL be sampled only in DECODE and MEMADR.

Reset
REQ-032 While rst_n=0, state SHALL be FETCH and PCWrite, IRWrite, MemWrite, RegWrite SHALL be forced to 0 regardless of MemReady.
REQ-033 rst_n asserted in any state, including mid-MEMWRITE, SHALL drop MemWrite combinationally in the same cycle; after release, the first rising edge evaluates FETCH.

Configuration
REQ-034 With ILLEGAL_OP_TRAP_EN defined, a TRAP state and output port Illegal (1 bit) SHALL exist; an unknown opcode in DECODE SHALL go to TRAP, which drives all enables to 0, sets Illegal=1 and holds until reset.
REQ-035 Without ILLEGAL_OP_TRAP_EN, neither TRAP nor Illegal SHALL exist, and unknown opcodes SHALL return to FETCH.

Structure
REQ-036 Package ctrl_pkg SHALL hold the state enum (4-bit), opcode constants, and the ResultSrc/ALUSrcA/ALUSrcB/ALUOp encodings; result_mux encodings SHALL match ctrl_pkg.
REQ-037 One sub-module, ctrl_output_decode (state, Zero, MemReady -> control word), SHALL be used; next-state logic and the state register remain in multicycle_ctrl.

Verification
REQ-038 add (op=0110011), MemReady=1 -> states FETCH,DECODE,EXECUTER,ALUWB; RegWrite=1 with ResultSrc=00 only in cycle 4.
REQ-039 lw with MemReady low for 3 cycles in MEMREAD -> MEMREAD held 4 cycles, then MEMWB with ResultSrc=01, RegWrite=1.
REQ-040 beq with Zero=1, then Zero=0 -> PCWrite=1/PCSrc=1 in BEQ, then PCWrite=0; both return to FETCH.
REQ-041 lui (0110111) -> ResultSrc=11, RegWrite=1 in cycle 3; jal -> ResultSrc=10, RegWrite=1, PCWrite=1.
REQ-042 rst_n driven low in MEMWRITE with MemReady=0 -> MemWrite=0 immediately; after release, state FETCH.
REQ-043 op=1111111 -> FETCH after DECODE (macro off); TRAP with Illegal=1 held until reset (ILLEGAL_OP_TRAP_EN on).

Source files
------------

// File: rtl/ctrl_pkg.sv
// rtl/ctrl_pkg.sv - state enum, opcodes and datapath mux encodings for the multicycle controller
// The TRAP state exists only when ILLEGAL_OP_TRAP_EN is defined.
package ctrl_pkg;

  typedef enum logic [3:0] {
    S_FETCH    = 4'd0,
    S_DECODE   = 4'd1,
    S_MEMADR   = 4'd2,
    S_MEMREAD  = 4'd3,
    S_MEMWB    = 4'd4,
    S_MEMWRITE = 4'd5,
    S_EXECUTER = 4'd6,
    S_EXECUTEI = 4'd7,
    S_ALUWB    = 4'd8,
    S_JAL      = 4'd9,
    S_BEQ      = 4'd10,
    S_LUI      = 4'd11
`ifdef ILLEGAL_OP_TRAP_EN
    , S_TRAP   = 4'd12
`endif
  } state_t;

  localparam logic [6:0] OP_LW    = 7'b0000011;
  localparam logic [6:0] OP_SW    = 7'b0100011;
  localparam logic [6:0] OP_RTYPE = 7'b0110011;
  localparam logic [6:0] OP_ITYPE = 7'b0010011;
  localparam logic [6:0] OP_JAL   = 7'b1101111;
  localparam logic [6:0] OP_BEQ   = 7'b1100011;
  localparam logic [6:0] OP_LUI   = 7'b0110111;

  // result_mux select
  localparam logic [1:0] RES_ALU    = 2'b00;
  localparam logic [1:0] RES_RDATA  = 2'b01;
  localparam logic [1:0] RES_PCP4   = 2'b10;
  localparam logic [1:0] RES_IMM    = 2'b11;

  localparam logic [1:0] SRCA_PC    = 2'b00;
  localparam logic [1:0] SRCA_OLDPC = 2'b01;
  localparam logic [1:0] SRCA_RS1   = 2'b10;

  localparam logic [1:0] SRCB_RS2   = 2'b00;
  localparam logic [1:0] SRCB_IMM   = 2'b01;
  localparam logic [1:0] SRCB_FOUR  = 2'b10;

  localparam logic [1:0] ALUOP_ADD  = 2'b00;
  localparam logic [1:0] ALUOP_SUB  = 2'b01;
  localparam logic [1:0] ALUOP_FUNC = 2'b10;

  typedef struct packed {
    logic       pc_write;
    logic       pc_src;
    logic       adr_src;
    logic       ir_write;
    logic       mem_write;
    logic       reg_write;
    logic [1:0] result_src;
    logic [1:0] alu_src_a;
    logic [1:0] alu_src_b;
    logic [1:0] alu_op;
  } ctrl_word_t;

endpackage

// File: rtl/ctrl_output_decode.sv
// rtl/ctrl_output_decode.sv - Moore output decode: state (plus Zero/MemReady qualifiers) to control word
module ctrl_output_decode
  import ctrl_pkg::*;
(
  input  state_t     state_i,
  input  logic       zero_i,
  input  logic       mem_ready_i,
  output ctrl_word_t ctrl_o
);

  always_comb begin
    ctrl_o = '0;
    unique case (state_i)
      S_FETCH: begin
        ctrl_o.adr_src    = 1'b0;
        ctrl_o.alu_src_a  = SRCA_PC;
        ctrl_o.alu_src_b  = SRCB_FOUR;
        ctrl_o.alu_op     = ALUOP_ADD;
        ctrl_o.result_src = RES_PCP4;
        ctrl_o.ir_write   = mem_ready_i;
        ctrl_o.pc_write   = mem_ready_i;
      end
      S_DECODE: begin
        ctrl_o.alu_src_a  = SRCA_OLDPC;
        ctrl_o.alu_src_b  = SRCB_IMM;
        ctrl_o.alu_op     = ALUOP_ADD;
      end
      S_MEMADR: begin
        ctrl_o.alu_src_a  = SRCA_RS1;
        ctrl_o.alu_src_b  = SRCB_IMM;
        ctrl_o.alu_op     = ALUOP_ADD;
      end
      S_MEMREAD:  ctrl_o.adr_src = 1'b1;
      S_MEMWB: begin
        ctrl_o.result_src = RES_RDATA;
        ctrl_o.reg_write  = 1'b1;
      end
      S_MEMWRITE: begin
        ctrl_o.adr_src    = 1'b1;
        ctrl_o.mem_write  = 1'b1;
      end
      S_EXECUTER: begin
        ctrl_o.alu_src_a  = SRCA_RS1;
        ctrl_o.alu_src_b  = SRCB_RS2;
        ctrl_o.alu_op     = ALUOP_FUNC;
      end
      S_EXECUTEI: begin
        ctrl_o.alu_src_a  = SRCA_RS1;
        ctrl_o.alu_src_b  = SRCB_IMM;
        ctrl_o.alu_op     = ALUOP_FUNC;
      end
      S_ALUWB: begin
        ctrl_o.result_src = RES_ALU;
        ctrl_o.reg_write  = 1'b1;
      end
      S_JAL: begin
        ctrl_o.result_src = RES_PCP4;
        ctrl_o.reg_write  = 1'b1;
        ctrl_o.pc_src     = 1'b1;
        ctrl_o.pc_write   = 1'b1;
      end
      S_BEQ: begin
        ctrl_o.alu_src_a  = SRCA_RS1;
        ctrl_o.alu_src_b  = SRCB_RS2;
        ctrl_o.alu_op     = ALUOP_SUB;
        ctrl_o.pc_src     = 1'b1;
        ctrl_o.pc_write   = zero_i;
      end
      S_LUI: begin
        ctrl_o.result_src = RES_IMM;
        ctrl_o.reg_write  = 1'b1;
      end
      default: ctrl_o = '0;
    endcase
  end

endmodule

// File: rtl/multicycle_ctrl.sv
// rtl/multicycle_ctrl.sv - multicycle RISC-V main controller FSM (state register + next-state logic)
// ILLEGAL_OP_TRAP_EN adds a sticky TRAP state and the Illegal output for unknown opcodes.
module multicycle_ctrl
  import ctrl_pkg::*;
(
  input  logic       clk,
  input  logic       rst_n,
  input  logic [6:0] op,
  input  logic       Zero,
  input  logic       MemReady,
  output logic       PCWrite,
  output logic       PCSrc,
  output logic       AdrSrc,
  output logic       IRWrite,
  output logic       MemWrite,
  output logic       RegWrite,
  output logic [1:0] ResultSrc,
  output logic [1:0] ALUSrcA,
  output logic [1:0] ALUSrcB,
  output logic [1:0] ALUOp
`ifdef ILLEGAL_OP_TRAP_EN
  ,
  output logic       Illegal
`endif
);

  state_t     state_q, state_d;
  ctrl_word_t ctrl;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= S_FETCH;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = S_FETCH;
    unique case (state_q)
      S_FETCH:    state_d = MemReady ? S_DECODE : S_FETCH;
      S_DECODE: begin
        case (op)
          OP_LW, OP_SW: state_d = S_MEMADR;
          OP_RTYPE:     state_d = S_EXECUTER;
          OP_ITYPE:     state_d = S_EXECUTEI;
          OP_JAL:       state_d = S_JAL;
          OP_BEQ:       state_d = S_BEQ;
          OP_LUI:       state_d = S_LUI;
`ifdef ILLEGAL_OP_TRAP_EN
          default:      state_d = S_TRAP;
`else
          default:      state_d = S_FETCH;
`endif
        endcase
      end
      S_MEMADR:   state_d = (op == OP_LW) ? S_MEMREAD : S_MEMWRITE;
      S_MEMREAD:  state_d = MemReady ? S_MEMWB : S_MEMREAD;
      S_MEMWRITE: state_d = MemReady ? S_FETCH : S_MEMWRITE;
      S_EXECUTER, S_EXECUTEI: state_d = S_ALUWB;
`ifdef ILLEGAL_OP_TRAP_EN
      S_TRAP:     state_d = S_TRAP;
`endif
      default:    state_d = S_FETCH;
    endcase
  end

  ctrl_output_decode u_decode (
    .state_i     (state_q),
    .zero_i      (Zero),
    .mem_ready_i (MemReady),
    .ctrl_o      (ctrl)
  );

  // Write enables are gated by rst_n so an in-flight store is dropped the moment reset asserts.
  assign PCWrite   = rst_n & ctrl.pc_write;
  assign IRWrite   = rst_n & ctrl.ir_write;
  assign MemWrite  = rst_n & ctrl.mem_write;
  assign RegWrite  = rst_n & ctrl.reg_write;
  assign PCSrc     = ctrl.pc_src;
  assign AdrSrc    = ctrl.adr_src;
  assign ResultSrc = ctrl.result_src;
  assign ALUSrcA   = ctrl.alu_src_a;
  assign ALUSrcB   = ctrl.alu_src_b;
  assign ALUOp     = ctrl.alu_op;

`ifdef ILLEGAL_OP_TRAP_EN
  assign Illegal = (state_q == S_TRAP);
`endif

endmodule

// File: tb/tb_multicycle_ctrl.sv
// tb/tb_multicycle_ctrl.sv - directed self-checking bench for multicycle_ctrl (covers ILLEGAL_OP_TRAP_EN when defined)
module tb_multicycle_ctrl;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [6:0] op;
  logic       Zero;
  logic       MemReady;
  logic       PCWrite, PCSrc, AdrSrc, IRWrite, MemWrite, RegWrite;
  logic [1:0] ResultSrc, ALUSrcA, ALUSrcB, ALUOp;
`ifdef ILLEGAL_OP_TRAP_EN
  logic       Illegal;
`endif

  int n_chk  = 0;
  int n_pass = 0;

  always #5 clk = ~clk;

  multicycle_ctrl dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .op        (op),
    .Zero      (Zero),
    .MemReady  (MemReady),
    .PCWrite   (PCWrite),
    .PCSrc     (PCSrc),
    .AdrSrc    (AdrSrc),
    .IRWrite   (IRWrite),
    .MemWrite  (MemWrite),
    .RegWrite  (RegWrite),
    .ResultSrc (ResultSrc),
    .ALUSrcA   (ALUSrcA),
    .ALUSrcB   (ALUSrcB),
    .ALUOp     (ALUOp)
`ifdef ILLEGAL_OP_TRAP_EN
    ,
    .Illegal   (Illegal)
`endif
  );

  // {PCWrite,PCSrc,AdrSrc,IRWrite,MemWrite,RegWrite,ResultSrc,ALUSrcA,ALUSrcB,ALUOp}
  logic [13:0] word;
  assign word = {PCWrite, PCSrc, AdrSrc, IRWrite, MemWrite, RegWrite,
                 ResultSrc, ALUSrcA, ALUSrcB, ALUOp};

  function automatic logic [13:0] w(input logic pcw, pcs, adr, irw, mw, rw,
                                    input logic [1:0] rs, a, b, aop);
    return {pcw, pcs, adr, irw, mw, rw, rs, a, b, aop};
  endfunction

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  // Called at a falling edge with inputs already set: sample, then advance one cycle.
  task automatic cyc(input string tag, input logic [13:0] exp);
    #1 check(tag, {18'd0, word}, {18'd0, exp});
    @(negedge clk);
  endtask

  localparam logic [13:0] W_FETCH   = 14'b1_0_0_1_0_0_10_00_10_00;
  localparam logic [13:0] W_FETCH0  = 14'b0_0_0_0_0_0_10_00_10_00;
  localparam logic [13:0] W_DECODE  = 14'b0_0_0_0_0_0_00_01_01_00;
  localparam logic [13:0] W_MEMADR  = 14'b0_0_0_0_0_0_00_10_01_00;
  localparam logic [13:0] W_MEMREAD = 14'b0_0_1_0_0_0_00_00_00_00;
  localparam logic [13:0] W_MEMWB   = 14'b0_0_0_0_0_1_01_00_00_00;
  localparam logic [13:0] W_MEMWR   = 14'b0_0_1_0_1_0_00_00_00_00;
  localparam logic [13:0] W_EXR     = 14'b0_0_0_0_0_0_00_10_00_10;
  localparam logic [13:0] W_EXI     = 14'b0_0_0_0_0_0_00_10_01_10;
  localparam logic [13:0] W_ALUWB   = 14'b0_0_0_0_0_1_00_00_00_00;
  localparam logic [13:0] W_JAL     = 14'b1_1_0_0_0_1_10_00_00_00;
  localparam logic [13:0] W_BEQT    = 14'b1_1_0_0_0_0_00_10_00_01;
  localparam logic [13:0] W_BEQN    = 14'b0_1_0_0_0_0_00_10_00_01;
  localparam logic [13:0] W_LUI     = 14'b0_0_0_0_0_1_11_00_00_00;

  initial begin
    rst_n = 1'b0; op = 7'b0110011; Zero = 1'b0; MemReady = 1'b1;
    repeat (3) @(negedge clk);
    check("reset_fetch_gated", {18'd0, word}, {18'd0, w(0,0,0,0,0,0,2'b10,2'b00,2'b10,2'b00)});

    rst_n = 1'b1;
    // add
    cyc("add_fetch", W_FETCH);
    cyc("add_decode", W_DECODE);
    op = 7'b1111111;
    cyc("add_execr", W_EXR);
    cyc("add_aluwb", W_ALUWB);

    // addi, with a FETCH stall first
    op = 7'b0010011; MemReady = 1'b0;
    cyc("fetch_stall", W_FETCH0);
    MemReady = 1'b1;
    cyc("addi_fetch", W_FETCH);
    cyc("addi_decode", W_DECODE);
    cyc("addi_execi", W_EXI);
    cyc("addi_aluwb", W_ALUWB);

    // lw, MemReady ignored in DECODE/MEMADR, low 3 cycles in MEMREAD
    op = 7'b0000011;
    cyc("lw_fetch", W_FETCH);
    MemReady = 1'b0;
    cyc("lw_decode", W_DECODE);
    cyc("lw_memadr", W_MEMADR);
    op = 7'b0100011;
    cyc("lw_memread0", W_MEMREAD);
    cyc("lw_memread1", W_MEMREAD);
    cyc("lw_memread2", W_MEMREAD);
    MemReady = 1'b1;
    cyc("lw_memread3", W_MEMREAD);
    cyc("lw_memwb", W_MEMWB);

    // sw completing normally after one wait cycle
    op = 7'b0100011;
    cyc("sw_fetch", W_FETCH);
    cyc("sw_decode", W_DECODE);
    cyc("sw_memadr", W_MEMADR);
    MemReady = 1'b0;
    cyc("sw_memwr_wait", W_MEMWR);
    MemReady = 1'b1;
    cyc("sw_memwr_done", W_MEMWR);

    // beq taken then not taken
    op = 7'b1100011; Zero = 1'b1;
    cyc("beq1_fetch", W_FETCH);
    cyc("beq1_decode", W_DECODE);
    cyc("beq_taken", W_BEQT);
    Zero = 1'b0;
    cyc("beq2_fetch", W_FETCH);
    cyc("beq2_decode", W_DECODE);
    cyc("beq_not_taken", W_BEQN);

    // lui, jal
    op = 7'b0110111;
    cyc("lui_fetch", W_FETCH);
    cyc("lui_decode", W_DECODE);
    cyc("lui_wb", W_LUI);
    op = 7'b1101111;
    cyc("jal_fetch", W_FETCH);
    cyc("jal_decode", W_DECODE);
    cyc("jal_wb", W_JAL);

    // reset asserted mid-store while memory is stalled
    op = 7'b0100011;
    cyc("swr_fetch", W_FETCH);
    cyc("swr_decode", W_DECODE);
    cyc("swr_memadr", W_MEMADR);
    MemReady = 1'b0;
    cyc("swr_memwr", W_MEMWR);
    rst_n = 1'b0;
    #1 check("swr_memwrite_drop", {31'd0, MemWrite}, 32'd0);
    check("swr_reset_word", {18'd0, word}, {18'd0, W_FETCH0});
    @(negedge clk);
    rst_n = 1'b1; MemReady = 1'b1; op = 7'b1111111;
    cyc("post_reset_fetch", W_FETCH);
    cyc("unk_decode", W_DECODE);
`ifdef ILLEGAL_OP_TRAP_EN
    #1 check("trap_word", {18'd0, word}, 32'd0);
    check("trap_illegal", {31'd0, Illegal}, 32'd1);
    repeat (3) @(negedge clk);
    #1 check("trap_hold", {31'd0, Illegal}, 32'd1);
    check("trap_hold_word", {18'd0, word}, 32'd0);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    #1 check("trap_cleared", {31'd0, Illegal}, 32'd0);
    @(negedge clk);
`else
    cyc("unk_back_fetch", W_FETCH);
`endif

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
